// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: consumer end of the RC4 keystream interface.
// Prefetches keystream bytes into a small FIFO and XORs them with the message
// stream. Encrypt and decrypt are the same operation.
// Optional build macro RC4_KS_DROP_EN: discard the first DROP_N keystream
// bytes after reset or flush (RC4-drop[DROP_N]).
module rc4_stream_xor #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16,
    parameter int DROP_N     = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             flush,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       ks_byte,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [7:0]       din,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [7:0]       dout,
    output logic             dout_last,
    output logic [LEN_W-1:0] byte_cnt,
    output logic             done,
    output logic             busy
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                  state;
    logic [FIFO_DEPTH-1:0][7:0]  mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic [LEN_W-1:0]            rem;
    logic                        flush_ok, start_ok, fifo_empty, fifo_full;
    logic                        push, pop, out_hs, drop_busy;

    assign flush_ok   = flush && (state == IDLE);
    assign start_ok   = start && (state == IDLE);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign out_hs     = dout_valid && dout_ready;
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);

`ifdef RC4_KS_DROP_EN
    localparam int DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
    logic [DW-1:0] drop_cnt;

    assign drop_busy = (drop_cnt != '0);

    // Drop counter: reloaded on reset/flush, counts down discarded keystream bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= DW'(DROP_N);
        else if (flush_ok)
            drop_cnt <= DW'(DROP_N);
        else if (drop_busy && ks_valid)
            drop_cnt <= drop_cnt - 1'b1;
    end
`else
    // Dropping disabled: the comparison is never true, DROP_N has no effect
    assign drop_busy = (DROP_N < 0);
`endif

    // Keystream is accepted while dropping, or while the FIFO has room outside DONE
    assign ks_ready  = drop_busy || ((state != DONE) && !fifo_full);
    // A flush wins over a same-cycle push so the new key starts from empty
    assign push      = ks_valid && ks_ready && !drop_busy && !flush_ok;
    assign din_ready = (state == RUN) && !fifo_empty && (rem != '0) &&
                       (!dout_valid || dout_ready) && !drop_busy;
    assign pop       = din_valid && din_ready;

    // Message FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= (msg_len == '0) ? DONE : RUN;
                RUN:     if (pop && rem == LEN_W'(1)) state <= DRAIN;
                DRAIN:   if (out_hs) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Remaining input byte count for the current message
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem <= '0;
        else if (start_ok)
            rem <= msg_len;
        else if (pop)
            rem <= rem - 1'b1;
    end

    // Keystream prefetch FIFO; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_ok) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ks_byte;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register: loads on input handshake, holds under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else if (pop) begin
            dout       <= din ^ mem[rd_ptr];
            dout_valid <= 1'b1;
            dout_last  <= (rem == LEN_W'(1));
        end else if (out_hs) begin
            dout_valid <= 1'b0;
        end
    end

    // Output byte counter, restarted by each accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            byte_cnt <= '0;
        else if (start_ok)
            byte_cnt <= '0;
        else if (out_hs)
            byte_cnt <= byte_cnt + 1'b1;
    end

endmodule
